// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SQI SRAM access arbiter.
// SRAM_ARB_FAIRNESS_EN enables the CPU anti-starvation counter.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_GAP
  } state_e;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  localparam logic [2:0] N_CMD      = 3'd2;
  localparam logic [2:0] N_ADDR     = 3'd6;
  localparam logic [2:0] N_DUMMY    = 3'd2;
  localparam logic [2:0] N_AUD_DATA = 3'd4;
  localparam logic [2:0] N_CPU_DATA = 3'd2;

  // Outgoing frame: opcode, 24-bit byte address, MSB-aligned data.
  function automatic logic [47:0] build_frame(
    input logic        we,
    input logic [23:0] addr,
    input logic [15:0] data
  );
    return {(we ? OP_WRITE : OP_READ), addr, data};
  endfunction

endpackage

// File: rtl/sram_sqi_shifter.sv
// SQI nibble engine: two-cycle nibble phase, frame shifter,
// per-segment nibble counter and receive shift register.
module sram_sqi_shifter
  import sram_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        run,
  input  logic [47:0] frame,
  input  logic [2:0]  seg_len,
  input  logic [3:0]  sio_in,
  output logic        phase,
  output logic        seg_done,
  output logic [3:0]  nib,
  output logic [15:0] rx_next
);

  logic        phase_q, phase_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [47:0] sr_q, sr_d;
  logic [15:0] rx_q, rx_d;

  assign phase = phase_q;
  assign nib   = sr_q[47:44];

  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    rx_d     = rx_q;
    rx_next  = {rx_q[11:0], sio_in};
    seg_done = run & phase_q &
               (cnt_q == seg_len - 3'd1);
    if (load) begin
      sr_d    = frame;
      phase_d = 1'b0;
      cnt_d   = '0;
    end else if (run) begin
      phase_d = ~phase_q;
      // phase1 ends the nibble: sample, shift, count
      if (phase_q) begin
        sr_d  = {sr_q[43:0], 4'h0};
        rx_d  = rx_next;
        cnt_d = seg_done ? 3'd0 : cnt_q + 3'd1;
      end
    end else begin
      phase_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      rx_q    <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Audio/CPU arbiter in front of a quad-SPI SRAM.
// Define SRAM_ARB_FAIRNESS_EN for bounded CPU starvation.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int CS_IDLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        aud_req,
  input  logic        aud_we,
  input  logic [16:0] aud_addr,
  input  logic [15:0] aud_wdata,
  output logic        aud_ack,
  output logic [15:0] aud_rdata,
  output logic        aud_rvalid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [16:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic        sram_spi_cs,
  output logic        sram_spi_clk,
  output logic [3:0]  sio_out,
  output logic        sio_oe,
  input  logic [3:0]  sio_in,
  output logic        busy
);

  localparam int GW = $clog2(CS_IDLE_CYCLES + 1);

  state_e      state_q, state_d;
  logic        aud_q, aud_d;
  logic        we_q, we_d;
  logic [GW-1:0] gap_q, gap_d;
  logic        aud_rv_q, aud_rv_d;
  logic        cpu_rv_q, cpu_rv_d;
  logic [15:0] aud_rd_q, aud_rd_d;
  logic [7:0]  cpu_rd_q, cpu_rd_d;

  logic        idle, run, cpu_win;
  logic        gnt_aud, gnt_cpu, load;
  logic        f_we;
  logic [23:0] f_addr;
  logic [15:0] f_data;
  logic [47:0] frame;
  logic [2:0]  seg_len;
  logic        phase, seg_done;
  logic [3:0]  nib;
  logic [15:0] rx_next;

  assign idle = (state_q == S_IDLE);
  assign run  = (state_q == S_CMD)  |
                (state_q == S_ADDR) |
                (state_q == S_DUMMY) |
                (state_q == S_DATA);

`ifdef SRAM_ARB_FAIRNESS_EN
  localparam int FW = $clog2(STARVE_LIMIT + 1);
  logic [FW-1:0] fair_q, fair_d;

  assign cpu_win = cpu_req &
    (~aud_req | (fair_q == FW'(STARVE_LIMIT)));

  always_comb begin
    fair_d = fair_q;
    if (!cpu_req || gnt_cpu)
      fair_d = '0;
    else if (gnt_aud)
      fair_d = fair_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fair_q <= '0;
    else          fair_q <= fair_d;
  end
`else
  assign cpu_win = cpu_req & ~aud_req;
`endif

  assign gnt_cpu = idle & cpu_win;
  assign gnt_aud = idle & aud_req & ~cpu_win;
  assign load    = gnt_aud | gnt_cpu;

  // ack is combinational in IDLE; masked so reset shows no grant
  assign aud_ack = reset_n & gnt_aud;
  assign cpu_ack = reset_n & gnt_cpu;

  assign f_we   = gnt_aud ? aud_we : cpu_we;
  assign f_addr = gnt_aud ? {6'd0, aud_addr, 1'b0}
                          : {7'd0, cpu_addr};
  assign f_data = gnt_aud ? aud_wdata
                          : {cpu_wdata, 8'h00};
  assign frame  = build_frame(f_we, f_addr, f_data);

  always_comb begin
    unique case (state_q)
      S_ADDR:  seg_len = N_ADDR;
      S_DUMMY: seg_len = N_DUMMY;
      S_DATA:  seg_len = aud_q ? N_AUD_DATA
                               : N_CPU_DATA;
      default: seg_len = N_CMD;
    endcase
  end

  sram_sqi_shifter u_shifter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .run      (run),
    .frame    (frame),
    .seg_len  (seg_len),
    .sio_in   (sio_in),
    .phase    (phase),
    .seg_done (seg_done),
    .nib      (nib),
    .rx_next  (rx_next)
  );

  always_comb begin
    state_d  = state_q;
    aud_d    = aud_q;
    we_d     = we_q;
    gap_d    = gap_q;
    aud_rv_d = 1'b0;
    cpu_rv_d = 1'b0;
    aud_rd_d = aud_rd_q;
    cpu_rd_d = cpu_rd_q;
    unique case (state_q)
      S_IDLE: if (load) begin
        state_d = S_CMD;
        aud_d   = gnt_aud;
        we_d    = f_we;
      end
      S_CMD: if (seg_done) state_d = S_ADDR;
      S_ADDR: if (seg_done)
        state_d = we_q ? S_DATA : S_DUMMY;
      S_DUMMY: if (seg_done) state_d = S_DATA;
      S_DATA: if (seg_done) begin
        state_d = S_GAP;
        gap_d   = '0;
        if (!we_q && aud_q) begin
          aud_rv_d = 1'b1;
          aud_rd_d = rx_next;
        end else if (!we_q) begin
          cpu_rv_d = 1'b1;
          cpu_rd_d = rx_next[7:0];
        end
      end
      S_GAP: begin
        if (gap_q == GW'(CS_IDLE_CYCLES - 1))
          state_d = S_IDLE;
        else
          gap_d = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      aud_q    <= 1'b0;
      we_q     <= 1'b0;
      gap_q    <= '0;
      aud_rv_q <= 1'b0;
      cpu_rv_q <= 1'b0;
      aud_rd_q <= '0;
      cpu_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      aud_q    <= aud_d;
      we_q     <= we_d;
      gap_q    <= gap_d;
      aud_rv_q <= aud_rv_d;
      cpu_rv_q <= cpu_rv_d;
      aud_rd_q <= aud_rd_d;
      cpu_rd_q <= cpu_rd_d;
    end
  end

  assign busy         = ~idle;
  assign sram_spi_cs  = ~run;
  assign sram_spi_clk = phase;
  assign sio_out      = run ? nib : 4'h0;
  assign sio_oe       = (state_q == S_CMD)  |
                        (state_q == S_ADDR) |
                        ((state_q == S_DATA) & we_q);
  assign aud_rvalid   = aud_rv_q;
  assign aud_rdata    = aud_rd_q;
  assign cpu_rvalid   = cpu_rv_q;
  assign cpu_rdata    = cpu_rd_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with an SQI SRAM stub.
// Fairness expectations follow SRAM_ARB_FAIRNESS_EN.
module tb_sram_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        aud_req, aud_we;
  logic [16:0] aud_addr;
  logic [15:0] aud_wdata;
  logic        aud_ack, aud_rvalid;
  logic [15:0] aud_rdata;
  logic        cpu_req, cpu_we;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        sram_spi_cs, sram_spi_clk;
  logic [3:0]  sio_out, sio_in;
  logic        sio_oe, busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_access_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .aud_req      (aud_req),
    .aud_we       (aud_we),
    .aud_addr     (aud_addr),
    .aud_wdata    (aud_wdata),
    .aud_ack      (aud_ack),
    .aud_rdata    (aud_rdata),
    .aud_rvalid   (aud_rvalid),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .cpu_rvalid   (cpu_rvalid),
    .sram_spi_cs  (sram_spi_cs),
    .sram_spi_clk (sram_spi_clk),
    .sio_out      (sio_out),
    .sio_oe       (sio_oe),
    .sio_in       (sio_in),
    .busy         (busy)
  );

  task automatic chk(input string tag,
                     input logic [47:0] got,
                     input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(tag, busy, 1'b0);
  endtask

  // One transaction; abort_k > 0 pulls reset at that nibble.
  task automatic txn(input string tag,
                     input logic aud, input logic we,
                     input logic [16:0] a,
                     input logic [15:0] d,
                     input logic [15:0] rd,
                     input logic [47:0] exp_nib,
                     input int exp_cyc,
                     input int abort_k);
    int t, cyc, k, nn;
    logic [47:0] nib;
    logic [15:0] rb;
    logic oe7, oe8, ack, rv;
    nn = we ? (aud ? 12 : 10) : 8;
    @(negedge clk);
    if (aud) begin
      aud_req = 1'b1; aud_we = we;
      aud_addr = a;   aud_wdata = d;
    end else begin
      cpu_req = 1'b1; cpu_we = we;
      cpu_addr = a;   cpu_wdata = d[15:8];
    end
    #1;
    t = 0;
    ack = aud ? aud_ack : cpu_ack;
    while (!ack && t < 100) begin
      @(negedge clk);
      t++;
      ack = aud ? aud_ack : cpu_ack;
    end
    chk({tag, "_ack"}, ack, 1'b1);
    @(negedge clk);
    aud_req = 1'b0;
    cpu_req = 1'b0;
    chk({tag, "_ack_pulse"},
        aud ? aud_ack : cpu_ack, 1'b0);
    cyc = 0; k = 0; nib = '0; rb = rd;
    oe7 = 1'bx; oe8 = 1'bx;
    while (!sram_spi_cs && cyc < 100) begin
      cyc++;
      if (!sram_spi_clk) begin
        if (k < nn) nib = {nib[43:0], sio_out};
        if (k == 7) oe7 = sio_oe;
        if (k == 8) oe8 = sio_oe;
        if (!we && k >= 10) begin
          sio_in = rb[15:12];
          rb = rb << 4;
        end
        if (abort_k > 0 && k == abort_k) begin
          #2 reset_n = 1'b0;
          #1;
          chk({tag, "_rst_cs"}, sram_spi_cs, 1'b1);
          chk({tag, "_rst_oe"}, sio_oe, 1'b0);
          chk({tag, "_rst_busy"}, busy, 1'b0);
          rv = 1'b0;
          repeat (3) begin
            @(negedge clk);
            rv = rv | aud_rvalid | cpu_rvalid;
          end
          reset_n = 1'b1;
          @(negedge clk);
          rv = rv | aud_rvalid | cpu_rvalid;
          chk({tag, "_rst_rvalid"}, rv, 1'b0);
          return;
        end
        k++;
      end
      @(negedge clk);
    end
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_nibbles"}, nib, exp_nib);
    if (!we) begin
      chk({tag, "_oe_addr"}, oe7, 1'b1);
      chk({tag, "_oe_dummy"}, oe8, 1'b0);
      if (aud) begin
        chk({tag, "_rvalid"}, aud_rvalid, 1'b1);
        chk({tag, "_rdata"}, aud_rdata, rd);
      end else begin
        chk({tag, "_rvalid"}, cpu_rvalid, 1'b1);
        chk({tag, "_rdata"}, cpu_rdata, rd[15:8]);
      end
      @(negedge clk);
      chk({tag, "_rvalid_pulse"},
          aud_rvalid | cpu_rvalid, 1'b0);
    end
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    int t;
    logic [4:0] seq, exp_seq;
    int g;
    reset_n = 1'b0;
    aud_req = 1'b1; aud_we = 1'b0;
    aud_addr = '0;  aud_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0;  cpu_wdata = '0;
    sio_in = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_cs", sram_spi_cs, 1'b1);
    chk("rst_sclk", sram_spi_clk, 1'b0);
    chk("rst_oe", sio_oe, 1'b0);
    chk("rst_sio", sio_out, 4'h0);
    chk("rst_ack", {aud_ack, cpu_ack}, 2'b00);
    chk("rst_rv", {aud_rvalid, cpu_rvalid}, 2'b00);
    chk("rst_rdata", {aud_rdata, cpu_rdata}, 24'h0);
    chk("rst_busy", busy, 1'b0);
    aud_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    txn("aud_wr", 1'b1, 1'b1, 17'h00010, 16'hBEEF,
        16'h0, 48'h0200_0020_BEEF, 24, 0);
    txn("cpu_rd", 1'b0, 1'b0, 17'h1FFFF, 16'h0,
        16'hA500, 48'h0301_FFFF, 24, 0);
    txn("aud_rd", 1'b1, 1'b0, 17'h1FFFF, 16'h0,
        16'h1234, 48'h0303_FFFE, 28, 0);
    txn("cpu_wr", 1'b0, 1'b1, 17'h00ABC, 16'h5A00,
        16'h0, 48'h02_000A_BC5A, 20, 0);
    chk("hold_cpu_rdata", cpu_rdata, 8'hA5);
    chk("hold_aud_rdata", aud_rdata, 16'h1234);

    @(negedge clk);
    aud_req = 1'b1; aud_we = 1'b1;
    aud_addr = 17'h0; aud_wdata = 16'h0;
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 17'h5; cpu_wdata = 8'h0;
    #1;
    chk("sim_aud_ack", aud_ack, 1'b1);
    chk("sim_cpu_ack", cpu_ack, 1'b0);
    @(negedge clk);
    aud_req = 1'b0;
    t = 1;
    while (!cpu_ack && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("sim_cpu_ack_time", t, 27);
    @(negedge clk);
    cpu_req = 1'b0;
    wait_idle("sim_idle");

    @(negedge clk);
    aud_req = 1'b1; aud_we = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1;
    #1;
    seq = '0; g = 0; t = 0;
    while (g < 5 && t < 400) begin
      if (aud_ack) begin
        seq = {seq[3:0], 1'b1}; g++;
      end else if (cpu_ack) begin
        seq = {seq[3:0], 1'b0}; g++;
      end
      @(negedge clk);
      t++;
    end
    aud_req = 1'b0;
    cpu_req = 1'b0;
`ifdef SRAM_ARB_FAIRNESS_EN
    exp_seq = 5'b11110;
`else
    exp_seq = 5'b11111;
`endif
    chk("fair_seq", seq, exp_seq);
    wait_idle("fair_idle");

    txn("abort", 1'b1, 1'b0, 17'h00100, 16'h0,
        16'hCAFE, 48'h0, 28, 10);
    chk("abort_rdata", aud_rdata, 16'h0);
    txn("post_rst", 1'b1, 1'b0, 17'h00100, 16'h0,
        16'hCAFE, 48'h0300_0200, 28, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
